// File: rtl/alu_nbit.sv
// N-bit ALU (add/sub with carry/borrow, logic, 1-bit shifts) with status flags; 1-cycle registered latency.
// No handshake and no stall: a new operation is accepted on every clock.
module alu_nbit #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  logic [3:0]           opcode,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  logic                 add_cin;
  logic                 sub_cin;
  logic [BUS_WIDTH:0]   sum_ext;
  logic [BUS_WIDTH:0]   diff_ext;
  logic [BUS_WIDTH-1:0] y_nxt;
  logic                 carry_nxt;
  logic                 borrow_nxt;
  logic                 invalid_nxt;

  // carry_in only participates in the chained forms; plain ADD/SUB force it to 0.
  assign add_cin  = carry_in & (opcode == OP_ADC);
  assign sub_cin  = carry_in & (opcode == OP_SBB);
  assign sum_ext  = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, add_cin};
  // Top bit of the (W+1)-bit difference is set exactly when a < b + cin.
  assign diff_ext = {1'b0, a} - {1'b0, b} - {{BUS_WIDTH{1'b0}}, sub_cin};

  always_comb begin
    y_nxt       = '0;
    carry_nxt   = 1'b0;
    borrow_nxt  = 1'b0;
    invalid_nxt = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        y_nxt     = sum_ext[BUS_WIDTH-1:0];
        carry_nxt = sum_ext[BUS_WIDTH];
      end
      OP_SUB, OP_SBB: begin
        y_nxt      = diff_ext[BUS_WIDTH-1:0];
        borrow_nxt = diff_ext[BUS_WIDTH];
      end
      OP_AND: y_nxt = a & b;
      OP_OR:  y_nxt = a | b;
      OP_XOR: y_nxt = a ^ b;
      OP_NOT: y_nxt = ~a;
      OP_SHL: begin
        y_nxt     = {a[BUS_WIDTH-2:0], 1'b0};
        carry_nxt = a[BUS_WIDTH-1];
      end
      OP_SHR: begin
        y_nxt     = {1'b0, a[BUS_WIDTH-1:1]};
        carry_nxt = a[0];
      end
      default: invalid_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y          <= '0;
      carry_out  <= 1'b0;
      borrow     <= 1'b0;
      zero       <= 1'b0;
      parity     <= 1'b0;
      invalid_op <= 1'b0;
    end else begin
      y          <= y_nxt;
      carry_out  <= carry_nxt;
      borrow     <= borrow_nxt;
      zero       <= ~|y_nxt;
      parity     <= ^y_nxt;
      invalid_op <= invalid_nxt;
    end
  end

endmodule

// File: tb/tb_alu_nbit.sv
// Bench for alu_nbit: arithmetic reference model checked every cycle, plus directed literal vectors.
module tb_alu_nbit;

  localparam int W = 16;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic [3:0]   opcode;
  logic [W-1:0] y;
  logic         carry_out;
  logic         borrow;
  logic         zero;
  logic         parity;
  logic         invalid_op;

  int checks   = 0;
  int failures = 0;

  alu_nbit #(.BUS_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .opcode     (opcode),
    .y          (y),
    .carry_out  (carry_out),
    .borrow     (borrow),
    .zero       (zero),
    .parity     (parity),
    .invalid_op (invalid_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: evaluates the opcode table with wide integer arithmetic at each rising edge.
  logic           model_vld = 1'b0;
  logic [W-1:0]   e_y;
  logic           e_co, e_bo, e_z, e_p, e_inv;
  longint unsigned av, bv, cv, r;

  always @(posedge clk) begin
    av = 64'(a); bv = 64'(b); cv = 64'(carry_in);
    r = 0; e_co = 0; e_bo = 0; e_inv = 0;
    if (!rst_n) begin
      e_y = '0; e_z = 0; e_p = 0;
    end else begin
      case (opcode)
        4'd0: begin r = av + bv;      e_co = ((r >> W) & 1) != 0; end
        4'd1: begin r = av + bv + cv; e_co = ((r >> W) & 1) != 0; end
        4'd2: begin r = av - bv;      e_bo = (av < bv); end
        4'd3: begin r = av - bv - cv; e_bo = (av < bv + cv); end
        4'd4: r = av & bv;
        4'd5: r = av | bv;
        4'd6: r = av ^ bv;
        4'd7: r = ~av;
        4'd8: begin r = av << 1; e_co = ((av >> (W - 1)) & 1) != 0; end
        4'd9: begin r = av >> 1; e_co = (av & 1) != 0; end
        default: e_inv = 1;
      endcase
      r   = r & MASK;
      e_y = r[W-1:0];
      e_z = (r == 0);
      e_p = ($countones(r) % 2) == 1;
    end
    model_vld = 1'b1;
  end

  always @(negedge clk) begin
    if (model_vld) begin
      check("cmp_y",       64'(y),          64'(e_y));
      check("cmp_carry",   64'(carry_out),  64'(e_co));
      check("cmp_borrow",  64'(borrow),     64'(e_bo));
      check("cmp_zero",    64'(zero),       64'(e_z));
      check("cmp_parity",  64'(parity),     64'(e_p));
      check("cmp_invalid", 64'(invalid_op), 64'(e_inv));
    end
  end

  task automatic drive(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci);
    opcode = op; a = aa; b = bb; carry_in = ci;
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [W-1:0] ey, input logic eco, input logic ebo,
                     input logic ez, input logic ep, input logic einv);
    check({nm, "_y"},       64'(y),          64'(ey));
    check({nm, "_carry"},   64'(carry_out),  64'(eco));
    check({nm, "_borrow"},  64'(borrow),     64'(ebo));
    check({nm, "_zero"},    64'(zero),       64'(ez));
    check({nm, "_parity"},  64'(parity),     64'(ep));
    check({nm, "_invalid"}, 64'(invalid_op), 64'(einv));
    check({nm, "_model_y"}, 64'(e_y),        64'(ey));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'd0, 16'd5, 16'd3, 1'b0);
    step(); step();
    lit("reset", 16'h0000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    lit("post_reset_add", 16'h0008, 0, 0, 0, 1, 0);

    drive(4'd0, 16'hFFFF, 16'h0001, 1'b0); step();
    lit("add_wrap", 16'h0000, 1, 0, 1, 0, 0);
    drive(4'd1, 16'hFFFF, 16'h0001, 1'b1); step();
    lit("adc_wrap", 16'h0001, 1, 0, 0, 1, 0);

    drive(4'd2, 16'd3, 16'd5, 1'b0); step();
    lit("sub_under", 16'hFFFE, 0, 1, 0, 1, 0);
    drive(4'd3, 16'd5, 16'd5, 1'b1); step();
    lit("sbb_under", 16'hFFFF, 0, 1, 0, 0, 0);

    drive(4'd6, 16'h00FF, 16'h0F0F, 1'b0); step();
    lit("xor", 16'h0FF0, 0, 0, 0, 0, 0);
    drive(4'd8, 16'h8001, 16'h0F0F, 1'b0); step();
    lit("shl", 16'h0002, 1, 0, 0, 1, 0);
    drive(4'd9, 16'h8001, 16'h0F0F, 1'b0); step();
    lit("shr", 16'h4000, 1, 0, 0, 1, 0);

    drive(4'd12, 16'd7, 16'd9, 1'b1); step();
    lit("invalid", 16'h0000, 0, 0, 1, 0, 1);
    drive(4'd5, 16'd7, 16'd9, 1'b0); step();
    lit("or_after_inv", 16'h000F, 0, 0, 0, 0, 0);

    drive(4'd7, 16'h1234, 16'hFFFF, 1'b1); step();
    lit("not", 16'hEDCB, 0, 0, 0, 1, 0);

    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < 25; j++) begin
        rst_n = !(i == 12 && j == 0);
        drive(4'((i + j) % 10), W'(i), W'(j), 1'((i % 2)));
        step();
        if (i == 12 && j == 0)
          lit("sweep_reset", 16'h0000, 0, 0, 0, 0, 0);
      end
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_nbit.md
Name: alu_nbit

Overview:
Parameterised N-bit combinational ALU datapath with registered outputs. It provides add/subtract (with carry/borrow chaining), bitwise logic, and 1-bit shifts, plus zero, parity and invalid-opcode status flags. It is used as the arithmetic execution block in the datapath, and all results appear one clock after the operands are sampled.

Parameters:
BUS_WIDTH, 16, width of operands a, b and result y (any value >= 2).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset; synchronous, active-low.
a  input  BUS_WIDTH  operand A (unsigned).
b  input  BUS_WIDTH  operand B (unsigned).
carry_in  input  1  carry/borrow-in for ADC/SBB.
opcode  input  4  operation select.
y  output  BUS_WIDTH  registered result.
carry_out  output  1  registered carry / shifted-out bit.
borrow  output  1  registered borrow from subtraction.
zero  output  1  registered flag; 1 when y == 0.
parity  output  1  registered flag; XOR-reduction of y (1 = odd number of ones).
invalid_op  output  1  registered flag; 1 for unused opcode.

Behaviour:
- One clock domain. Synchronous active-low reset: on a rising clk edge with rst_n=0, all outputs (y, carry_out, borrow, zero, parity, invalid_op) are set to 0. Reset takes priority over any operation in flight.
- Latency is 1 cycle. Inputs are sampled at rising edge N, and the outputs computed from them are valid after edge N and held until edge N+1.
- There is no handshake and no enable: a new operation is issued every cycle.
- Opcode map (all arithmetic unsigned, modulo 2^BUS_WIDTH):
  - 0 ADD: y = a+b. carry_out = bit BUS_WIDTH of the sum.
  - 1 ADC: y = a+b+carry_in. carry_out = bit BUS_WIDTH of the sum.
  - 2 SUB: y = a-b. borrow = (a < b).
  - 3 SBB: y = a-b-carry_in. borrow = (a < b+carry_in), evaluated at BUS_WIDTH+1 bits.
  - 4 AND: y = a & b.
  - 5 OR: y = a | b.
  - 6 XOR: y = a ^ b.
  - 7 NOT: y = ~a. b is ignored.
  - 8 SHL: y = a<<1, LSB filled with 0. carry_out = a[MSB].
  - 9 SHR: y = a>>1 (logical), MSB filled with 0. carry_out = a[0].
  - 10-15: invalid. y = 0, carry_out = 0, borrow = 0, invalid_op = 1.
- carry_out = 0 for opcodes 2-7. borrow = 0 for every opcode except 2 and 3.
- carry_in is ignored except for opcodes 1 and 3.
- invalid_op = 0 for opcodes 0-9.
- zero and parity are always derived from the next y value, including invalid opcodes (invalid gives zero=1, parity=0).
- Wrap-around: an add overflow truncates y and sets carry_out. A subtract underflow yields the two's-complement wrap and sets borrow.
- X/Z on inputs is not handled and carries no requirement.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with a=5, b=3, opcode=0 -> all outputs 0. Release rst_n -> after the next edge y=8, carry_out=0, zero=0, parity=1.
- Add wrap, BUS_WIDTH=16: a=16'hFFFF, b=1, opcode=0 -> y=0, carry_out=1, zero=1, parity=0. Same operands with carry_in=1, opcode=1 -> y=1, carry_out=1, zero=0, parity=1.
- Subtract: a=3, b=5, opcode=2 -> y=16'hFFFE, borrow=1, parity=1. Then a=5, b=5, carry_in=1, opcode=3 -> y=16'hFFFF, borrow=1, parity=0.
- Logic/shift: a=16'h00FF, b=16'h0F0F, opcode=6 -> y=16'h0FF0, parity=0. Then a=16'h8001, opcode=8 -> y=16'h0002, carry_out=1. Then opcode=9 -> y=16'h4000, carry_out=1.
- Invalid: opcode=12, a=7, b=9 -> y=0, invalid_op=1, zero=1, carry_out=0, borrow=0. Next cycle opcode=5 -> invalid_op=0, y=16'h000F.
- Sweep and latency: a=i, b=j for i,j in 0..24, carry_in=i%2, opcode=(i+j)%10, one vector per cycle -> each output matches a golden model of the previous cycle's inputs. Assert rst_n=0 mid-sweep -> outputs are 0 after that edge.
